// File: rtl/fx2_fifo_reader.sv
// FX2LP slave-FIFO OUT-endpoint reader: packs 4 bytes into one 32-bit IQ word
// and streams buffered words out on a valid/ready port.
module fx2_fifo_reader #(
  parameter logic [1:0] EP_ADDR      = 2'b00,
  parameter int         DEPTH        = 4,
  parameter int         IDLE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       iq_swap,
  input  logic [7:0]                 fd_in,
  input  logic                       flag_empty_n,
  output logic                       slrd_n,
  output logic                       sloe_n,
  output logic [1:0]                 fifoadr,
  output logic                       bus_active,
  output logic [31:0]                m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [31:0]                word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_READ
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_empty;
  logic [TW-1:0] r_to_cnt;
  logic [1:0]    r_idx;
  logic [23:0]   r_part;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic [31:0]   r_wcnt;

  logic          w_rd;
  logic          w_to;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head;

  assign w_to   = r_empty && (r_to_cnt == TO_LAST);
  assign w_push = w_rd && (r_idx == 2'd3);
  assign w_pop  = m_valid && m_ready;
  assign w_head = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    sloe_n = 1'b1;
    slrd_n = 1'b1;
    w_rd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable && !r_empty) w_next = S_ARM;
      end
      S_ARM: begin
        sloe_n = 1'b0;
        w_next = S_READ;
      end
      S_READ: begin
        sloe_n = 1'b0;
        w_rd   = enable && !r_empty && (r_level != FULL);
        slrd_n = !w_rd;
        if (!enable || w_to) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Consecutive-empty counter; only runs while the bus is held in READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == S_READ && r_empty) begin
      r_to_cnt <= w_to ? '0 : r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!flush && w_push) begin
      r_mem[r_wr] <= {fd_in, r_part};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_empty <= 1'b1;
      r_idx   <= '0;
      r_part  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_wcnt  <= '0;
    end else begin
      r_empty <= !flag_empty_n;
      if (flush) begin
        r_idx   <= '0;
        r_part  <= '0;
        r_wr    <= '0;
        r_rd    <= '0;
        r_level <= '0;
      end else begin
        if (w_rd) begin
          r_idx <= r_idx + 1'b1;
          if (w_push) r_wr <= r_wr + 1'b1;
          else        r_part[{r_idx, 3'b000} +: 8] <= fd_in;
        end
        if (w_pop) begin
          r_rd   <= r_rd + 1'b1;
          r_wcnt <= r_wcnt + 1'b1;
        end
        if (w_push && !w_pop)      r_level <= r_level + 1'b1;
        else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      end
    end
  end

  assign fifoadr    = EP_ADDR;
  assign bus_active = !sloe_n;
  assign m_valid    = (r_level != '0);
  assign m_data     = iq_swap ? {w_head[15:0], w_head[31:16]} : w_head;
  assign level      = r_level;
  assign word_count = r_wcnt;

endmodule

// File: doc/fx2_fifo_reader.md
Name: fx2_fifo_reader

Overview:
- Transmit-direction counterpart of the FX2LP slave-FIFO writer in the ADC SDR receive path.
- Reads the FX2LP OUT endpoint byte by byte over the synchronous slave-FIFO interface (FD, SLRDN, SLOEN, FIFOADR, EMPTY flag).
- Assembles each group of 4 bytes into one 32-bit {Q[15:0], I[15:0]} word, buffers words in a small internal FIFO, and presents them on a valid/ready stream to the DAC/upconverter path.
- Runs on IFCLK (48 MHz).

Parameters:
- EP_ADDR, 2'b00: value driven on FIFOADR while active.
- DEPTH, 4: internal word FIFO depth, in words; power of 2, minimum 2.
- IDLE_TIMEOUT, 16: consecutive cycles of EMPTY in READ before releasing the bus (returning to IDLE).

Ports:
- clk  in  1  IFCLK; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  bus grant / run request (from pio); 0 releases the FD bus.
- flush  in  1  one-cycle pulse; discards the partial word and the FIFO contents.
- iq_swap  in  1  1: output {I, Q} instead of {Q, I}.
- fd_in  in  8  FD pins (read side).
- flag_empty_n  in  1  FX2 EP EMPTY flag, active low (0 = empty).
- slrd_n  out  1  SLRDN.
- sloe_n  out  1  SLOEN.
- fifoadr  out  2  FIFOADR.
- bus_active  out  1  1 while SLOEN is asserted; the top-level FD tristate control uses it.
- m_data  out  32  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- level  out  log2(DEPTH)+1  number of words held in the internal FIFO.
- word_count  out  32  total words popped; wraps at 2^32.

Behaviour:
- Reset values:
  - slrd_n = 1, sloe_n = 1, fifoadr = EP_ADDR, bus_active = 0.
  - m_valid = 0, m_data = 0, level = 0, word_count = 0.
  - byte index = 0, partial word cleared, state = IDLE.
- Flag sampling: flag_empty_n is registered once (empty_r) before use. The FX2 EMPTY flag updates by the edge after a read, so the registered flag is the only qualifier.
- FSM:
  - IDLE: sloe_n = 1, slrd_n = 1. Go to ARM when enable = 1 and empty_r = 0.
  - ARM: sloe_n = 0, slrd_n = 1, one cycle only (output-enable setup). Go to READ.
  - READ: sloe_n = 0.
    - slrd_n = 0 in a cycle iff enable = 1, empty_r = 0, and level < DEPTH.
    - Each cycle with slrd_n = 0 captures fd_in at that posedge into byte[idx], then idx increments mod 4.
    - Go to IDLE when enable = 0, or when empty_r has been 0-data (empty) for IDLE_TIMEOUT consecutive cycles.
- Byte order is little-endian: byte0 → [7:0], byte1 → [15:8], byte2 → [23:16], byte3 → [31:24]. Nominal [15:0] = I, [31:16] = Q.
- Word push: the capture of byte3 pushes the word into the FIFO in the same edge. m_valid can rise the next cycle, so latency from the byte3 read to m_valid is 1 cycle.
- Slot reservation: reading is gated on level < DEPTH. A partial word therefore always has a slot free (pop only lowers level), so the FIFO never overflows.
- Partial words:
  - EMPTY or enable = 0 mid-word: hold the partial bytes and idx; resume on re-entry.
  - ARM re-entry does not reset idx.
- Output: standard valid/ready.
  - m_data is stable while m_valid = 1 and m_ready = 0.
  - Pop on m_valid & m_ready; word_count increments on each pop.
  - Push and pop in the same cycle leave level unchanged.
- iq_swap is applied at the FIFO output mux, i.e. {m_data[15:0], m_data[31:16]}; it takes effect combinationally.
- flush has priority over push and pop in that cycle:
  - level → 0, idx → 0, m_valid → 0.
  - word_count is unchanged.
  - The FSM state is unchanged; a read in the same cycle is discarded.
- Reset mid-operation: all state returns to reset values next edge, and slrd_n/sloe_n deassert at that edge.
- word_count wraps from 0xFFFFFFFF to 0.

Test Plan:
- Model FX2 with 8 bytes 01..08, enable = 1, m_ready = 1 → words 0x04030201 then 0x08070605; sloe_n low 1 cycle before the first slrd_n; word_count = 2; after IDLE_TIMEOUT empty cycles, sloe_n = 1.
- m_ready = 0, 24 bytes available, DEPTH = 4 → exactly 16 reads, level = 4, slrd_n stays 1; raise m_ready → remaining 8 bytes read, 6 words out in order, no loss or duplication.
- EMPTY asserted after byte 2 for 10 cycles, then 2 more bytes → one word assembled correctly (0xDDCCBBAA for AA, BB, CC, DD).
- iq_swap = 1 on word 0x22221111 → m_data = 0x11112222.
- flush after 3 bytes read while 2 words are queued → level = 0, m_valid = 0; the next 4 bytes 10..13 give 0x13121110.
- Reset during READ with slrd_n low → next cycle slrd_n = 1, sloe_n = 1, level = 0, word_count = 0.
